// File: rtl/logic_pkg.sv
// Shared definitions for the bitwise logic unit and its successors.
// Op codes (OP_AND .. OP_PASS) and the op-select width OP_W.
package logic_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND  = 3'd0;
    localparam logic [OP_W-1:0] OP_OR   = 3'd1;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
    localparam logic [OP_W-1:0] OP_NAND = 3'd3;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
    localparam logic [OP_W-1:0] OP_NOT  = 3'd6;
    localparam logic [OP_W-1:0] OP_PASS = 3'd7;

endpackage

// File: rtl/logic_op.sv
// Combinational bitwise operator: result = op(in0, in1).
// Ports: in0/in1 (WIDTH) operands, op (OP_W) select, result (WIDTH).
module logic_op
    import logic_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        unique case (op)
            OP_AND:  result = in0 & in1;
            OP_OR:   result = in0 | in1;
            OP_XOR:  result = in0 ^ in1;
            OP_NAND: result = ~(in0 & in1);
            OP_NOR:  result = ~(in0 | in1);
            OP_XNOR: result = ~(in0 ^ in1);
            OP_NOT:  result = ~in0;
            OP_PASS: result = in0;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered logic unit: logic_op feeding a 2-entry result FIFO.
// Ports: clk, rst (async high), in_valid/in_ready/in0/in1/op in,
// out_valid/out_ready/out out; zr/ng only with LOGIC_FLAGS_EN.
module logic_unit_pipe
    import logic_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [OP_W-1:0]  op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
`ifdef LOGIC_FLAGS_EN
    ,
    output logic             zr,
    output logic             ng
`endif
);

    // Entry layout: {zr, ng, data} with flags, plain data without.
`ifdef LOGIC_FLAGS_EN
    localparam int EW = WIDTH + 2;
`else
    localparam int EW = WIDTH;
`endif

    logic [WIDTH-1:0] res;
    logic [EW-1:0]    ent_new;
    logic [EW-1:0]    ent_rst;

    logic [EW-1:0] e0_q, e0_d;
    logic [EW-1:0] e1_q, e1_d;
    logic [1:0]    count_q, count_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          push, pop;

    logic_op #(.WIDTH(WIDTH)) u_op (
        .in0    (in0),
        .in1    (in1),
        .op     (op),
        .result (res)
    );

`ifdef LOGIC_FLAGS_EN
    assign ent_new = {(res == '0), res[WIDTH-1], res};
    assign ent_rst = {1'b1, 1'b0, {WIDTH{1'b0}}};
`else
    assign ent_new = res;
    assign ent_rst = '0;
`endif

    assign push = in_valid && in_ready_q;
    assign pop  = out_valid_q && out_ready;

    // e0 is the head. It is left untouched when the queue drains,
    // so out keeps the last popped value while out_valid is low.
    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (!push && pop) begin
            count_d = count_q - 2'd1;
        end
        unique case (count_q)
            2'd0: begin
                if (push) e0_d = ent_new;
            end
            2'd1: begin
                if (push && pop) begin
                    e0_d = ent_new;
                end else if (push) begin
                    e1_d = ent_new;
                end
            end
            2'd2: begin
                if (pop) e0_d = e1_q;
            end
            default: begin
                e0_d = e0_q;
            end
        endcase
        in_ready_d  = (count_d != 2'd2);
        out_valid_d = (count_d != 2'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0_q        <= ent_rst;
            e1_q        <= ent_rst;
            count_q     <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            e0_q        <= e0_d;
            e1_q        <= e1_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = e0_q[WIDTH-1:0];
`ifdef LOGIC_FLAGS_EN
    assign zr        = e0_q[WIDTH+1];
    assign ng        = e0_q[WIDTH];
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: queue model plus directed vectors.
// Flag checks are active when LOGIC_FLAGS_EN is defined.
module tb_logic_unit_pipe;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in0 = '0;
    logic [W-1:0] in1 = '0;
    logic [2:0]   op = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out;
    logic         zr;
    logic         ng;

    logic_unit_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in0       (in0),
        .in1       (in1),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
`ifdef LOGIC_FLAGS_EN
        ,
        .zr        (zr),
        .ng        (ng)
`endif
    );

`ifndef LOGIC_FLAGS_EN
    assign zr = 1'b0;
    assign ng = 1'b0;
`endif

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int dut_pops = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] f_op(input logic [2:0] o,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            case (o)
                3'd0: r[i] = a[i] && b[i];
                3'd1: r[i] = a[i] || b[i];
                3'd2: r[i] = a[i] != b[i];
                3'd3: r[i] = !(a[i] && b[i]);
                3'd4: r[i] = !(a[i] || b[i]);
                3'd5: r[i] = a[i] == b[i];
                3'd6: r[i] = !a[i];
                default: r[i] = a[i];
            endcase
        end
        return r;
    endfunction

    // Reference: FIFO of results plus the last value shown on out.
    logic [W-1:0] mq[$];
    logic [W-1:0] m_last = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_last = '0;
        end else begin
            automatic bit m_push = in_valid && (mq.size() < 2);
            automatic bit m_pop  = (mq.size() > 0) && out_ready;
            if (m_pop) m_last = mq.pop_front();
            if (m_push) mq.push_back(f_op(op, in0, in1));
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            automatic logic [W-1:0] e_out;
            e_out = (mq.size() > 0) ? mq[0] : m_last;
            chk("model in_ready", 64'(in_ready), 64'(mq.size() < 2));
            chk("model out_valid", 64'(out_valid), 64'(mq.size() > 0));
            chk("model out", 64'(out), 64'(e_out));
`ifdef LOGIC_FLAGS_EN
            chk("model zr", 64'(zr), 64'(e_out == '0));
            chk("model ng", 64'(ng), 64'(e_out[W-1]));
`endif
            if (out_valid && out_ready) dut_pops++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] o,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = v;
        op       = o;
        in0      = a;
        in1      = b;
    endtask

    logic [W-1:0] sweep_exp [8];
    int p0;

    initial begin
        sweep_exp[0] = 16'hF000; sweep_exp[1] = 16'hFFF0;
        sweep_exp[2] = 16'h0FF0; sweep_exp[3] = 16'h0FFF;
        sweep_exp[4] = 16'h000F; sweep_exp[5] = 16'hF00F;
        sweep_exp[6] = 16'h0F0F; sweep_exp[7] = 16'hF0F0;

        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk); #1;
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd1);
        chk("rst out", 64'(out), 64'd0);
`ifdef LOGIC_FLAGS_EN
        chk("rst zr", 64'(zr), 64'd1);
        chk("rst ng", 64'(ng), 64'd0);
`endif

        // Op sweep, one result per cycle
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i), 16'hF0F0, 16'hFF00);
            step();
            chk("sweep out", 64'(out), 64'(sweep_exp[i]));
            chk("sweep valid", 64'(out_valid), 64'd1);
        end
        drive(1'b0, 3'd0, '0, '0);
        step();
        chk("sweep drained", 64'(out_valid), 64'd0);

        // Backpressure fill
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 16'hA5A5, 16'hFFFF);
        step();
        chk("bp rdy after 1", 64'(in_ready), 64'd1);
        drive(1'b1, 3'd1, 16'h0000, 16'h0001);
        step();
        chk("bp rdy after 2", 64'(in_ready), 64'd0);
        drive(1'b1, 3'd2, 16'h1234, 16'h1234);
        step();
        chk("bp rdy full", 64'(in_ready), 64'd0);
        chk("bp head", 64'(out), 64'hA5A5);
        drive(1'b0, 3'd0, '0, '0);
        out_ready = 1'b1;
        step();
        chk("bp second", 64'(out), 64'h0001);
        chk("bp rdy back", 64'(in_ready), 64'd1);
        step();
        chk("bp empty", 64'(out_valid), 64'd0);
        chk("bp hold", 64'(out), 64'h0001);

        // 100-operand stream, no bubbles
        p0 = dut_pops;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 3'(i % 8), 16'(i * 257) ^ 16'h5A5A, 16'(i));
            step();
            chk("stream valid", 64'(out_valid), 64'd1);
        end
        drive(1'b0, 3'd0, '0, '0);
        step();
        @(negedge clk); #1;
        chk("stream pops", 64'(dut_pops - p0), 64'd100);
        chk("stream done", 64'(out_valid), 64'd0);

        // Flags
        drive(1'b1, 3'd2, 16'h8000, 16'h8000);
        step();
        chk("flag xor out", 64'(out), 64'h0000);
`ifdef LOGIC_FLAGS_EN
        chk("flag xor zr", 64'(zr), 64'd1);
        chk("flag xor ng", 64'(ng), 64'd0);
`endif
        drive(1'b1, 3'd1, 16'h8000, 16'h0001);
        step();
        chk("flag or out", 64'(out), 64'h8001);
`ifdef LOGIC_FLAGS_EN
        chk("flag or zr", 64'(zr), 64'd0);
        chk("flag or ng", 64'(ng), 64'd1);
`endif
        drive(1'b0, 3'd0, '0, '0);
        step();

        // Stall hold
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 16'h00FF, 16'h0F0F);
        step();
        drive(1'b0, 3'd0, '0, '0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall out", 64'(out), 64'h000F);
            chk("stall valid", 64'(out_valid), 64'd1);
`ifdef LOGIC_FLAGS_EN
            chk("stall zr", 64'(zr), 64'd0);
            chk("stall ng", 64'(ng), 64'd0);
`endif
        end
        out_ready = 1'b1;
        step();

        // Reset mid-stream with two entries held
        out_ready = 1'b0;
        drive(1'b1, 3'd1, 16'h1111, 16'h2222);
        step();
        drive(1'b1, 3'd7, 16'hBEEF, 16'h0000);
        step();
        drive(1'b0, 3'd0, '0, '0);
        chk("pre-rst full", 64'(in_ready), 64'd0);
        #1 rst = 1'b1;
        #1;
        chk("mid rst valid", 64'(out_valid), 64'd0);
        chk("mid rst ready", 64'(in_ready), 64'd1);
        chk("mid rst out", 64'(out), 64'd0);
`ifdef LOGIC_FLAGS_EN
        chk("mid rst zr", 64'(zr), 64'd1);
`endif
        @(posedge clk);
        #3 rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
